btb_plru_tracker: RTL and testbench
===================================

// Module: btb_plru_tracker
// PURPOSE
//  Registered tree-PLRU replacement state for the set-associative branch target buffer.
//  Generalises the 2-way, 8-set 1-bit LRU to NUM_SETS x NUM_WAYS.
//  Takes one lookup touch and one update touch per cycle, and returns the victim way of a queried set.
//  Sits beside the BTB tag/target arrays; the fetch stage drives lookup, the execute/resolve stage drives update.
// PARAMETERS
//  NUM_SETS  8  sets in the BTB; power of 2, >=2; IDX_W = $clog2(NUM_SETS)
//  NUM_WAYS  2  ways per set; power of 2, 2..8; WAY_W = $clog2(NUM_WAYS); tree bits per set = NUM_WAYS-1
// PORTS
//  clk            in   1      clock
//  rst            in   1      asynchronous reset, active-high
//  flush          in   1      synchronous clear of all PLRU state
//  lookup_valid   in   1      fetch lookup this cycle
//  lookup_hit     in   1      lookup hit; touch only when lookup_valid & lookup_hit
//  lookup_index   in   IDX_W  set of lookup
//  lookup_way     in   WAY_W  way that hit
//  update_valid   in   1      BTB write this cycle
//  update_index   in   IDX_W  set being written
//  update_way     in   WAY_W  way being written (normally victim_way)
//  victim_index   in   IDX_W  set queried for replacement
//  victim_way     out  WAY_W  way to replace in victim_index
// BEHAVIOUR
//  - State: NUM_SETS entries of NUM_WAYS-1 tree bits, flopped on clk.
//  - Tree nodes are heap-ordered: node n has children 2n+1 and 2n+2. Leaves map to ways 0..NUM_WAYS-1, left to right.
//  - Node bit 0 = victim lies in the left (lower) subtree; bit 1 = victim lies in the right subtree.
//  - Touch(set, w): every node on the root-to-w path is set to point away from w. Nodes off the path are unchanged.
//    2-way example: touching way0 sets the bit to 1, touching way1 sets it to 0.
//  - victim_way: combinational walk of the REGISTERED state of victim_index. No bypass of same-cycle touches.
//  - Touch latency: 1 cycle. A touch is visible on victim_way in the cycle after the clk edge.
//  - Both ports touch in one cycle:
//    - Different sets: both touches apply.
//    - Same set: lookup touch is applied first, then update touch; update wins on shared path nodes.
//    - Same set and same way: result equals a single touch.
//  - flush: all state <= 0 at the next edge and overrides all touches in that cycle. Touches in the following cycle apply normally.
//  - Reset: all state = 0, giving victim_way = 0 for every set. rst asserted mid-operation clears state immediately (async).
//  - No index range check is needed; index widths exactly cover NUM_SETS.
//  - Out-of-range lookup_way/update_way cannot occur because NUM_WAYS is a power of 2.
//  - lookup_hit=0 or lookup_valid=0: no lookup touch. update_valid=0: no update touch.
// CONFIGURATION
//  BTB_PLRU_INVALID_FIRST_EN
//   - Defined: adds input victim_valid_mask [NUM_WAYS-1:0], the per-way valid bits of victim_index.
//     If any bit is 0, victim_way = lowest-index invalid way; otherwise victim_way = tree result.
//     The mask has no effect on state.
//   - Undefined: port absent; victim_way is always the tree result.
// STRUCTURE
//  - btb_pkg: BTB_NUM_SETS / BTB_NUM_WAYS defaults and typedef plru_bits_t (logic [NUM_WAYS-2:0]).
//  - btb_pkg also holds functions plru_touch(bits, way) and plru_victim(bits), as tree walks over node index.
//  - Sub-module plru_tree_touch: combinational, (bits_in, way, en) -> bits_out.
//    Instantiated twice and chained (lookup then update) on the write-back path for a same-set collision.
//    The other-set write uses its own instance output.
//  - Top: state array, two index decoders, victim mux, and the optional invalid-first priority encoder.
// TESTING
//  1. Reset, NUM_WAYS=4: victim_way = 0 for sets 0..7. Hold rst mid-run after touches -> all sets return victim 0 immediately.
//  2. NUM_WAYS=4, set 3: touch ways 0,1,2,3 on consecutive cycles. Then victim(3) = 0; touch 0 -> victim 2; touch 2 -> victim 1.
//  3. NUM_WAYS=2, same cycle: lookup hit set 5 way 0 and update set 5 way 1 -> next cycle victim(5) = 0 (update wins).
//     Repeat with update set 6 -> victim(5) = 1 and victim(6) = 0.
//  4. lookup_valid=1, lookup_hit=0, set 2 way 0 -> victim(2) unchanged. Victim is queried in the same cycle as a touch -> old value, new value the next cycle.
//  5. flush together with update set 1 way 0 -> next cycle all sets victim 0; touch set 1 way 0 the cycle after -> victim(1) = 1.
//  6. BTB_PLRU_INVALID_FIRST_EN, NUM_WAYS=4, mask=4'b1011 -> victim 2.
//     mask=4'b1111 -> tree result; state unchanged by mask changes.

Source files
------------

// File: rtl/btb_pkg.sv
// Shared BTB PLRU defaults, state typedef and tree-walk helpers.
// Helpers work on a max-size (8-way) tree; callers pass the real level count.
package btb_pkg;

  localparam int unsigned BTB_NUM_SETS  = 8;
  localparam int unsigned BTB_NUM_WAYS  = 2;
  localparam int unsigned PLRU_MAX_BITS = 7;
  localparam int unsigned PLRU_MAX_LVLS = 3;

  typedef logic [BTB_NUM_WAYS-2:0]  plru_bits_t;
  typedef logic [PLRU_MAX_BITS-1:0] plru_max_t;

  // Point every node on the root-to-way path away from that way.
  function automatic plru_max_t plru_touch(plru_max_t bits, logic [2:0] way,
                                           int unsigned lvls);
    plru_max_t   res;
    int unsigned node;
    logic        dir;
    res  = bits;
    node = 0;
    for (int unsigned l = 0; l < PLRU_MAX_LVLS; l++) begin
      if (l < lvls) begin
        dir            = way[2'(lvls - 1 - l)];
        res[3'(node)]  = ~dir;
        node           = 2 * node + 1 + 32'(dir);
      end
    end
    return res;
  endfunction

  // Follow node bits from the root down to the victim leaf.
  function automatic logic [2:0] plru_victim(plru_max_t bits, int unsigned lvls);
    logic [2:0]  way;
    int unsigned node;
    logic        dir;
    way  = 3'b000;
    node = 0;
    for (int unsigned l = 0; l < PLRU_MAX_LVLS; l++) begin
      if (l < lvls) begin
        dir  = bits[3'(node)];
        way  = {way[1:0], dir};
        node = 2 * node + 1 + 32'(dir);
      end
    end
    return way;
  endfunction

endpackage

// File: rtl/plru_tree_touch.sv
// Combinational tree-PLRU touch of one set's node bits; passes bits through when en is low.
module plru_tree_touch
  import btb_pkg::*;
#(
  parameter  int unsigned NUM_WAYS = BTB_NUM_WAYS,
  localparam int unsigned WAY_W    = $clog2(NUM_WAYS),
  localparam int unsigned TREE_W   = NUM_WAYS - 1
) (
  input  logic [TREE_W-1:0] bits_in,
  input  logic [WAY_W-1:0]  way,
  input  logic              en,
  output logic [TREE_W-1:0] bits_out
);

  plru_max_t touched;

  always_comb begin
    touched  = plru_touch(PLRU_MAX_BITS'(bits_in), 3'(way), WAY_W);
    bits_out = en ? TREE_W'(touched) : bits_in;
  end

endmodule

// File: rtl/btb_plru_tracker.sv
// Registered tree-PLRU state for the BTB: lookup + update touches per cycle, victim query.
// Optional BTB_PLRU_INVALID_FIRST_EN adds victim_valid_mask to prefer invalid ways.
module btb_plru_tracker
  import btb_pkg::*;
#(
  parameter  int unsigned NUM_SETS = BTB_NUM_SETS,
  parameter  int unsigned NUM_WAYS = BTB_NUM_WAYS,
  localparam int unsigned IDX_W    = $clog2(NUM_SETS),
  localparam int unsigned WAY_W    = $clog2(NUM_WAYS),
  localparam int unsigned TREE_W   = NUM_WAYS - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             lookup_valid,
  input  logic             lookup_hit,
  input  logic [IDX_W-1:0] lookup_index,
  input  logic [WAY_W-1:0] lookup_way,
  input  logic             update_valid,
  input  logic [IDX_W-1:0] update_index,
  input  logic [WAY_W-1:0] update_way,
  input  logic [IDX_W-1:0] victim_index,
`ifdef BTB_PLRU_INVALID_FIRST_EN
  input  logic [NUM_WAYS-1:0] victim_valid_mask,
`endif
  output logic [WAY_W-1:0] victim_way
);

  logic [TREE_W-1:0] state [NUM_SETS];
  logic              lk_en;
  logic              up_en;
  logic              same_set;
  logic [TREE_W-1:0] lk_bits;
  logic [TREE_W-1:0] up_base;
  logic [TREE_W-1:0] up_bits;
  logic [WAY_W-1:0]  tree_victim;

  always_comb begin
    lk_en    = lookup_valid & lookup_hit;
    up_en    = update_valid;
    same_set = lk_en && (lookup_index == update_index);
    // Same-set collision: update touch applies on top of the lookup result.
    up_base  = same_set ? lk_bits : state[update_index];
  end

  plru_tree_touch #(.NUM_WAYS(NUM_WAYS)) u_lookup_touch (
    .bits_in  (state[lookup_index]),
    .way      (lookup_way),
    .en       (lk_en),
    .bits_out (lk_bits)
  );

  plru_tree_touch #(.NUM_WAYS(NUM_WAYS)) u_update_touch (
    .bits_in  (up_base),
    .way      (update_way),
    .en       (up_en),
    .bits_out (up_bits)
  );

  // Update write follows lookup write so it wins when both target one set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_SETS); i++) state[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < int'(NUM_SETS); i++) state[i] <= '0;
    end else begin
      if (lk_en) state[lookup_index] <= lk_bits;
      if (up_en) state[update_index] <= up_bits;
    end
  end

  always_comb begin
    tree_victim = WAY_W'(plru_victim(PLRU_MAX_BITS'(state[victim_index]), WAY_W));
  end

`ifdef BTB_PLRU_INVALID_FIRST_EN
  // Lowest-index invalid way takes priority over the tree choice.
  always_comb begin
    victim_way = tree_victim;
    for (int i = int'(NUM_WAYS) - 1; i >= 0; i--) begin
      if (!victim_valid_mask[i]) victim_way = WAY_W'(i);
    end
  end
`else
  always_comb begin
    victim_way = tree_victim;
  end
`endif

endmodule

// File: tb/tb_btb_plru_tracker.sv
// Scoreboard bench for btb_plru_tracker (8 sets x 4 ways) against a range-splitting PLRU model.
// Honours BTB_PLRU_INVALID_FIRST_EN when defined.
module tb_btb_plru_tracker;

  localparam int unsigned SETS  = 8;
  localparam int unsigned WAYS  = 4;
  localparam int unsigned IDX_W = 3;
  localparam int unsigned WAY_W = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic             lookup_valid = 1'b0;
  logic             lookup_hit = 1'b0;
  logic [IDX_W-1:0] lookup_index = '0;
  logic [WAY_W-1:0] lookup_way = '0;
  logic             update_valid = 1'b0;
  logic [IDX_W-1:0] update_index = '0;
  logic [WAY_W-1:0] update_way = '0;
  logic [IDX_W-1:0] victim_index = '0;
  logic [WAY_W-1:0] victim_way;
`ifdef BTB_PLRU_INVALID_FIRST_EN
  logic [WAYS-1:0]  victim_valid_mask = '1;
`endif

  btb_plru_tracker #(.NUM_SETS(SETS), .NUM_WAYS(WAYS)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .lookup_valid (lookup_valid),
    .lookup_hit   (lookup_hit),
    .lookup_index (lookup_index),
    .lookup_way   (lookup_way),
    .update_valid (update_valid),
    .update_index (update_index),
    .update_way   (update_way),
    .victim_index (victim_index),
`ifdef BTB_PLRU_INVALID_FIRST_EN
    .victim_valid_mask (victim_valid_mask),
`endif
    .victim_way   (victim_way)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int exp_q[$];
  string tag_q[$];

  // Model: per set, one "victim side" flag per internal node, located by
  // tree level and the aligned way range that node covers.
  logic mdl [SETS][WAYS-1];

  function automatic void m_clear();
    for (int s = 0; s < int'(SETS); s++)
      for (int n = 0; n < int'(WAYS) - 1; n++) mdl[s][n] = 1'b0;
  endfunction

  function automatic void m_touch(int s, int w);
    int span;
    int node;
    for (int l = 0; (1 << l) < int'(WAYS); l++) begin
      span = int'(WAYS) >> l;
      node = (1 << l) - 1 + w / span;
      mdl[s][node] = ((w % span) < span / 2) ? 1'b1 : 1'b0;
    end
  endfunction

  function automatic int m_victim(int s, logic [3:0] msk);
    int lo;
    int span;
    int lvl;
    int node;
`ifdef BTB_PLRU_INVALID_FIRST_EN
    for (int w = 0; w < int'(WAYS); w++) if (!msk[w]) return w;
`else
    if (msk == 4'hF) lo = 0;
`endif
    lo   = 0;
    span = int'(WAYS);
    lvl  = 0;
    while (span > 1) begin
      node = (1 << lvl) - 1 + lo / span;
      if (mdl[s][node]) lo = lo + span / 2;
      span = span / 2;
      lvl++;
    end
    return lo;
  endfunction

  // Drive one cycle of stimulus, push the expected victim, then advance the model.
  task automatic step(input string tag, input logic r, input logic f,
                      input logic lv, input logic lh, input int li, input int lw,
                      input logic uv, input int ui, input int uw,
                      input int vi, input logic [3:0] msk);
    @(posedge clk);
    #1;
    rst          = r;
    flush        = f;
    lookup_valid = lv;
    lookup_hit   = lh;
    lookup_index = IDX_W'(li);
    lookup_way   = WAY_W'(lw);
    update_valid = uv;
    update_index = IDX_W'(ui);
    update_way   = WAY_W'(uw);
    victim_index = IDX_W'(vi);
`ifdef BTB_PLRU_INVALID_FIRST_EN
    victim_valid_mask = msk;
`endif
    if (r) m_clear();
    exp_q.push_back(m_victim(vi, msk));
    tag_q.push_back(tag);
    if (!r) begin
      if (f) m_clear();
      else begin
        if (lv && lh) m_touch(li, lw);
        if (uv) m_touch(ui, uw);
      end
    end
  endtask

  task automatic query(input string tag, input int vi, input logic [3:0] msk);
    step(tag, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 0, 0, vi, msk);
  endtask

  // Monitor: compares the DUT victim against the queued expectation mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      int    e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      vectors++;
      if (int'(victim_way) != e) begin
        miscompares++;
        $display("FAIL %s: victim_way=%0d expected=%0d (t=%0t)", t, victim_way, e, $time);
      end
    end
  end

  initial begin
    logic [3:0] msk;
    int li, ui;
    m_clear();

    // Reset state for every set.
    for (int s = 0; s < int'(SETS); s++)
      step("reset", 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 0, 0, s, 4'hF);

    // Set 3: touch ways 0..3 in order, then victim 0; touch 0 -> 2; touch 2 -> 1.
    for (int w = 0; w < int'(WAYS); w++)
      step("seq_touch", 1'b0, 1'b0, 1'b1, 1'b1, 3, w, 1'b0, 0, 0, 3, 4'hF);
    query("seq_v0", 3, 4'hF);
    step("seq_t0", 1'b0, 1'b0, 1'b1, 1'b1, 3, 0, 1'b0, 0, 0, 3, 4'hF);
    query("seq_v2", 3, 4'hF);
    step("seq_t2", 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 3, 2, 3, 4'hF);
    query("seq_v1", 3, 4'hF);

    // Same-cycle collisions: same set (update wins), different sets.
    step("coll_same", 1'b0, 1'b0, 1'b1, 1'b1, 5, 0, 1'b1, 5, 1, 5, 4'hF);
    query("coll_same_v", 5, 4'hF);
    step("coll_sameway", 1'b0, 1'b0, 1'b1, 1'b1, 4, 3, 1'b1, 4, 3, 4, 4'hF);
    query("coll_sameway_v", 4, 4'hF);
    step("coll_diff", 1'b0, 1'b0, 1'b1, 1'b1, 5, 0, 1'b1, 6, 1, 5, 4'hF);
    query("coll_diff_v5", 5, 4'hF);
    query("coll_diff_v6", 6, 4'hF);

    // Lookup miss does not touch; same-cycle query sees old state.
    step("miss", 1'b0, 1'b0, 1'b1, 1'b0, 2, 0, 1'b0, 0, 0, 2, 4'hF);
    query("miss_v", 2, 4'hF);
    step("no_bypass", 1'b0, 1'b0, 1'b1, 1'b1, 2, 0, 1'b0, 0, 0, 2, 4'hF);
    query("after_touch", 2, 4'hF);

    // Flush overrides a same-cycle touch, then touches resume.
    step("flush", 1'b0, 1'b1, 1'b1, 1'b1, 3, 1, 1'b1, 1, 0, 1, 4'hF);
    for (int s = 0; s < int'(SETS); s++) query("post_flush", s, 4'hF);
    step("touch_after_flush", 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 1, 0, 1, 4'hF);
    query("touch_after_flush_v", 1, 4'hF);

`ifdef BTB_PLRU_INVALID_FIRST_EN
    query("mask_1011", 1, 4'b1011);
    query("mask_0110", 1, 4'b0110);
    query("mask_full", 1, 4'b1111);
`endif

    // Mid-run asynchronous reset clears every set immediately.
    step("pre_rst", 1'b0, 1'b0, 1'b1, 1'b1, 7, 1, 1'b1, 0, 0, 7, 4'hF);
    for (int s = 0; s < int'(SETS); s++)
      step("mid_rst", 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 0, 0, s, 4'hF);

    // Randomized traffic with collisions, misses, flushes and occasional reset.
    for (int c = 0; c < 600; c++) begin
      li  = int'($urandom_range(0, SETS - 1));
      ui  = ($urandom_range(0, 2) == 0) ? li : int'($urandom_range(0, SETS - 1));
      msk = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      step("rand", ($urandom_range(0, 99) == 0), ($urandom_range(0, 39) == 0),
           1'($urandom), ($urandom_range(0, 3) != 0), li, int'($urandom_range(0, WAYS - 1)),
           1'($urandom), ui, int'($urandom_range(0, WAYS - 1)),
           ($urandom_range(0, 1) == 0) ? li : int'($urandom_range(0, SETS - 1)), msk);
    end

    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
